// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences WB-issued TLBSRCH/TLBRD/TLBWR/TLBFILL ops and picks the FILL victim.
// Build option TLB_RAND_LFSR_EN: victim source becomes a max-length LFSR instead of a wrapping counter.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op_type,
  output logic             op_ready,
  output logic             op_done,
  input  logic             flush,
  input  logic [IDX_W-1:0] csr_tlbidx_index,
  input  logic [18:0]      csr_vppn,
  input  logic [9:0]       csr_asid,
  output logic             s_req,
  input  logic             s_gnt,
  output logic [18:0]      s_vppn,
  output logic [9:0]       s_asid,
  input  logic             s_hit,
  input  logic [IDX_W-1:0] s_index,
  output logic [IDX_W-1:0] r_index,
  output logic             tlbrd_we,
  output logic             tlbsrch_we,
  output logic             tlbsrch_hit,
  output logic [IDX_W-1:0] tlbsrch_hit_index,
  output logic             we,
  output logic [IDX_W-1:0] w_index,
  output logic             refetch_flush
);
  localparam logic [2:0] OP_SRCH = 3'd1;
  localparam logic [2:0] OP_RD   = 3'd2;
  localparam logic [2:0] OP_WR   = 3'd3;
  localparam logic [2:0] OP_FILL = 3'd4;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_SRSP, S_RD, S_WR, S_DONE} state_t;
  state_t           r_state, w_next;
  logic [2:0]       r_op;
  logic [IDX_W-1:0] r_victim, r_rand, r_hit_index;
  logic             r_hit, w_accept;
  assign w_accept = op_valid && !flush && r_state == S_IDLE;
  assign s_vppn   = csr_vppn;
  assign s_asid   = csr_asid;
  assign r_index  = csr_tlbidx_index;
  assign w_index  = r_op == OP_FILL ? r_victim : csr_tlbidx_index;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_victim    <= '0;
      r_hit       <= 1'b0;
      r_hit_index <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= op_type;
        if (op_type == OP_FILL) r_victim <= r_rand;
      end
      if (r_state == S_SRSP) begin
        r_hit       <= s_hit;
        r_hit_index <= s_index;
      end
    end
  end
  // Strobes are gated by resetn so a reset landing mid-op never fires a write.
  always_comb begin
    w_next            = r_state;
    op_ready          = r_state == S_IDLE;
    s_req             = 1'b0;
    tlbsrch_we        = 1'b0;
    tlbrd_we          = 1'b0;
    we                = 1'b0;
    op_done           = 1'b0;
    refetch_flush     = 1'b0;
    tlbsrch_hit       = r_hit;
    tlbsrch_hit_index = r_hit_index;
    case (r_state)
      S_IDLE: if (w_accept)
        w_next = op_type == OP_SRCH ? S_ARB :
                 op_type == OP_RD   ? S_RD  :
                 (op_type == OP_WR || op_type == OP_FILL) ? S_WR : S_DONE;
      S_ARB: begin
        s_req  = resetn;
        w_next = flush ? S_IDLE : s_gnt ? S_SRSP : S_ARB;
      end
      S_SRSP: begin
        tlbsrch_we        = resetn;
        tlbsrch_hit       = s_hit;
        tlbsrch_hit_index = s_index;
        w_next            = S_DONE;
      end
      S_RD: begin
        tlbrd_we = resetn;
        w_next   = S_DONE;
      end
      S_WR: begin
        we     = resetn;
        w_next = S_DONE;
      end
      S_DONE: begin
        op_done       = resetn;
        refetch_flush = resetn && (r_op == OP_RD || r_op == OP_WR || r_op == OP_FILL);
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end
`ifdef TLB_RAND_LFSR_EN
  localparam logic [7:0] TAPS8 = IDX_W == 2 ? 8'b0000_0011 :
                                 IDX_W == 3 ? 8'b0000_0110 :
                                 IDX_W == 4 ? 8'b0000_1100 :
                                 IDX_W == 5 ? 8'b0001_0100 :
                                 IDX_W == 6 ? 8'b0011_0000 :
                                 IDX_W == 7 ? 8'b0110_0000 : 8'b1011_1000;
  localparam logic [IDX_W-1:0] TAPS = TAPS8[IDX_W-1:0];
  always_ff @(posedge clk) begin
    if (!resetn) r_rand <= IDX_W'(1);
    else r_rand <= {r_rand[IDX_W-2:0], ^(r_rand & TAPS)};
  end
`else
  always_ff @(posedge clk) begin
    if (!resetn) r_rand <= '0;
    else r_rand <= r_rand == IDX_W'(TLBNUM - 1) ? '0 : r_rand + 1'b1;
  end
`endif
endmodule
